// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared constants for the instruction-side sram-like to AXI read bridge:
// AXI field encodings, AR state encodings and a response classifier.
package inst_sram_axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_WAIT = 1'b1;

   // SLVERR (2'b10) and DECERR (2'b11) both carry bit 1.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Instruction fetch bridge: sram-like req/addr_ok/data_ok to single-beat in-order AXI reads.
// Optional feature macro IBRIDGE_RRESP_CHECK_EN reports rresp errors on inst_sram_err.
module inst_sram_axi_bridge
   import inst_sram_axi_bridge_pkg::*;
#(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] AXI_ID    = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_sram_err,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             ret;

   // NOTE: reset is synchronous, so the registers still hold old values during the
   // first reset cycle; the handshake outputs are gated with resetn to read 0 throughout.
   assign inst_sram_addr_ok = resetn && (state == AR_IDLE) && inst_sram_req && (cnt < CNT_MAX);
   assign accept            = inst_sram_addr_ok;
   assign rready            = resetn && (cnt != '0);
   assign ret               = rvalid && rready;

   assign inst_sram_data_ok = ret;
   assign inst_sram_rdata   = rdata;

`ifdef IBRIDGE_RRESP_CHECK_EN
   assign inst_sram_err = ret && resp_is_err(rresp);
`else
   assign inst_sram_err = 1'b0;
`endif

   assign arid    = AXI_ID;
   assign arlen   = 8'd0;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // Single ID and single-beat bursts: rid and rlast carry no information; wr is never set.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, rid, rlast, rresp};

   // NOTE: sequential state uses non-blocking assignments only, so every always_ff
   // reads the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= AR_IDLE;
         arvalid <= 1'b0;
         araddr  <= '0;
         arsize  <= '0;
      end else begin
         case (state)
            AR_IDLE: begin
               if (accept) begin
                  araddr  <= inst_sram_addr;
                  arsize  <= {1'b0, inst_sram_size};
                  arvalid <= 1'b1;
                  state   <= AR_WAIT;
               end
            end
            AR_WAIT: begin
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  state   <= AR_IDLE;
               end
            end
            default: state <= AR_IDLE;
         endcase
      end
   end

   // Accept and return in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (accept && !ret) begin
         cnt <= cnt + CNT_W'(1);
      end else if (ret && !accept) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Randomized scoreboard bench for inst_sram_axi_bridge with a behavioural AXI slave.
// Honours IBRIDGE_RRESP_CHECK_EN for the expected error flag.
module tb_inst_sram_axi_bridge;
   import inst_sram_axi_bridge_pkg::*;

   localparam int MAX_OUTST = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
   } ar_exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [31:0] addr = '0;
   logic        addr_ok, data_ok, err;
   logic [31:0] inst_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [3:0]  rid = 4'd0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = 2'b00;
   logic        rlast = 1'b1;
   logic        rvalid = 1'b0;
   logic        rready;

   inst_sram_axi_bridge #(.MAX_OUTST(MAX_OUTST), .AXI_ID(4'd0)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
      .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
      .inst_sram_rdata(inst_rdata), .inst_sram_err(err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: requests outstanding, whether an AR is waiting, and expectations.
   int          m_outst   = 0;
   bit          m_ar_busy = 1'b0;
   logic [31:0] m_ar_addr = '0;
   bit          exp_addr_ok, exp_rready, exp_arvalid, exp_data_ok;
   bit          mon_en  = 1'b0;
   bit          r_fired = 1'b0;
   bit          spur_on = 1'b0;
   ar_exp_t     exp_ar_q[$];
   logic [31:0] exp_r_q[$];
   logic [31:0] slave_q[$];

   function automatic logic [31:0] ref_data(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   function automatic logic [1:0] pick_resp();
      int r = $urandom_range(7);
      if (r == 5) return 2'b10;
      if (r == 6) return 2'b11;
      if (r == 7) return 2'b01;
      return AXI_RESP_OKAY;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; model expectations for this cycle are settled at +3.
   task automatic cycle(input bit rst, input int req_pct, input int ardy_pct,
                        input int rv_pct, input bit spurious);
      logic [31:0] a;
      @(posedge clk);
      #1;
      resetn = !rst;
      req    = ($urandom_range(99) < req_pct);
      a      = $urandom() & 32'hffff_fffc;
      if ($urandom_range(1) == 0) a[31:16] = 16'hbfc0;
      addr   = a;
      size   = ($urandom_range(3) == 0) ? 2'($urandom_range(1)) : 2'd2;
      arready = !rst && ($urandom_range(99) < ardy_pct);
      if (r_fired) begin
         rvalid  = 1'b0;
         r_fired = 1'b0;
      end
      if (spur_on && !spurious) begin
         rvalid  = 1'b0;
         spur_on = 1'b0;
      end
      if (rst) begin
         rvalid  = 1'b0;
         spur_on = 1'b0;
      end else if (!rvalid) begin
         if (spurious) begin
            rvalid  = 1'b1;
            rdata   = $urandom();
            rresp   = 2'b10;
            spur_on = 1'b1;
         end else if (slave_q.size() != 0 && $urandom_range(99) < rv_pct) begin
            rvalid = 1'b1;
            rdata  = ref_data(slave_q[0]);
            rresp  = pick_resp();
         end
      end
      #2;
      exp_arvalid = m_ar_busy;
      exp_addr_ok = resetn && req && !m_ar_busy && (m_outst < MAX_OUTST);
      exp_rready  = resetn && (m_outst != 0);
      exp_data_ok = rvalid && exp_rready;
      if (!resetn) begin
         m_outst   = 0;
         m_ar_busy = 1'b0;
         exp_ar_q.delete();
         exp_r_q.delete();
         slave_q.delete();
      end else begin
         if (exp_addr_ok) begin
            exp_ar_q.push_back('{addr: addr, size: {1'b0, size}});
            exp_r_q.push_back(ref_data(addr));
            m_ar_busy = 1'b1;
            m_ar_addr = addr;
         end else if (m_ar_busy && arready) begin
            slave_q.push_back(m_ar_addr);
            m_ar_busy = 1'b0;
         end
         if (exp_data_ok) begin
            void'(slave_q.pop_front());
            r_fired = 1'b1;
         end
         m_outst = m_outst + int'(exp_addr_ok) - int'(exp_data_ok);
      end
   endtask

   // Monitor: compares what the DUT presents against the model and the scoreboards.
   always @(negedge clk) begin
      if (mon_en) begin
         check("addr_ok", addr_ok, exp_addr_ok);
         check("rready", rready, exp_rready);
         check("data_ok", data_ok, exp_data_ok);
         check("arvalid", arvalid, exp_arvalid);
`ifdef IBRIDGE_RRESP_CHECK_EN
         check("err", err, exp_data_ok && rresp[1]);
`else
         check("err", err, 1'b0);
`endif
         if (resetn && arvalid === 1'b1) begin
            if (exp_ar_q.size() == 0) begin
               check("ar_unexpected", arvalid, 1'b0);
            end else begin
               check("araddr", araddr, exp_ar_q[0].addr);
               check("arsize", arsize, exp_ar_q[0].size);
               if (arready) begin
                  check("arid", arid, 4'd0);
                  check("arlen", arlen, 8'd0);
                  check("arburst", arburst, AXI_BURST_INCR);
                  check("arlock_cache_prot", {arlock, arcache, arprot}, 9'd0);
                  void'(exp_ar_q.pop_front());
               end
            end
         end
         if (resetn && data_ok === 1'b1) begin
            if (exp_r_q.size() == 0) check("data_unexpected", data_ok, 1'b0);
            else check("rdata", inst_rdata, exp_r_q.pop_front());
         end
      end
   end

   initial begin
      // Reset held with req asserted.
      cycle(1'b1, 100, 0, 0, 1'b0);
      mon_en = 1'b1;
      repeat (3) cycle(1'b1, 100, 0, 0, 1'b0);
      // Spurious beats with nothing outstanding must be refused.
      repeat (3) cycle(1'b0, 0, 100, 0, 1'b1);
      cycle(1'b0, 0, 100, 0, 1'b0);
      // A single fast request, then a long arready stall with requests pending.
      cycle(1'b0, 100, 100, 100, 1'b0);
      repeat (4) cycle(1'b0, 0, 100, 100, 1'b0);
      repeat (8) cycle(1'b0, 100, 0, 50, 1'b0);
      // Randomized traffic blocks, with one mid-run reset.
      for (int b = 0; b < 16; b++) begin
         int rq = $urandom_range(100, 30);
         int ar = $urandom_range(100, 20);
         int rv = (b % 4 == 1) ? 5 : $urandom_range(90, 10);
         for (int i = 0; i < 100; i++) cycle(b == 8 && i == 50, rq, ar, rv, 1'b0);
      end
      // Drain everything still in flight, bounded.
      for (int i = 0; i < 200 && (m_outst != 0 || m_ar_busy); i++) cycle(1'b0, 0, 100, 100, 1'b0);
      repeat (2) cycle(1'b0, 0, 100, 100, 1'b0);
      check("drain_ar_q", exp_ar_q.size(), 0);
      check("drain_r_q", exp_r_q.size(), 0);
      check("drain_outst", m_outst, 0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
